// File: rtl/pl_preload_master.sv
`default_nettype none
// ============================================================================
// Module   : pl_preload_master
// Purpose  : Initiator for the BRAM preload bus. Turns a command plus an
//            optional write-data stream into bus write bursts, constant fills
//            or read bursts on a chain of TDP18K tiles, and returns read-back
//            words on a valid/last stream.
// Ports    : PL_CLK_i / PL_RESET_i     clock, async active-high reset
//            CMD_*                     command handshake (op, id, addr, len, fill)
//            WD_*                      write-word stream for write commands
//            RD_*                      read-back stream (no backpressure)
//            BUSY_o / DONE_o / ERR_o   status
//            PL_*                      preload bus towards the tile chain
// Revision : 1.0 - initial release
// ============================================================================
module pl_preload_master #(
  parameter int READ_LAT = 1,
  parameter int MAX_LEN  = 1024
) (
  input  logic        PL_CLK_i,
  input  logic        PL_RESET_i,
  input  logic        CMD_VALID_i,
  output logic        CMD_READY_o,
  input  logic [1:0]  CMD_OP_i,
  input  logic [19:0] CMD_RAM_ID_i,
  input  logic [9:0]  CMD_ADDR_i,
  input  logic [10:0] CMD_LEN_i,
  input  logic [17:0] CMD_FILL_i,
  input  logic        WD_VALID_i,
  output logic        WD_READY_o,
  input  logic [17:0] WD_DATA_i,
  output logic        RD_VALID_o,
  output logic [17:0] RD_DATA_o,
  output logic        RD_LAST_o,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic        ERR_o,
  output logic        PL_ENA_o,
  output logic        PL_WEN_o,
  output logic        PL_REN_o,
  output logic [31:0] PL_ADDR_o,
  output logic [17:0] PL_DATA_o,
  input  logic [17:0] PL_RDATA_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_FILL  = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam logic [1:0]  OP_FILL  = 2'b10;
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);
  localparam int          DW       = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

  state_t          state, state_nxt;
  logic [19:0]     ram_id;
  logic [9:0]      waddr;
  logic [10:0]     remaining;
  logic [17:0]     fill_data;
  logic            is_read;
  logic [DW-1:0]   drain_cnt;

  // Bus-side next values produced by the FSM and registered below.
  logic            ena_nxt, wen_nxt, ren_nxt;
  logic [31:0]     addr_nxt;
  logic [17:0]     data_nxt;
  logic            issue_nxt, issue_last_nxt;
  logic            step;
  logic            accept;
  logic            cmd_illegal;

  // Marks bus cycles carrying a genuine read word (drain re-issues excluded)
  // and delays them by READ_LAT to line up with the tile response.
  logic                rd_issue, rd_issue_last;
  logic [READ_LAT-1:0] vld_sr, last_sr;

  assign cmd_illegal = (CMD_OP_i == 2'b11) || (CMD_LEN_i == 11'd0) ||
                       (CMD_LEN_i > LEN_MAX) ||
                       ((CMD_OP_i == OP_READ) && (CMD_RAM_ID_i == 20'd0));

  assign BUSY_o = (state == S_WRITE) || (state == S_FILL) ||
                  (state == S_READ)  || (state == S_DRAIN);
  assign DONE_o = (state == S_DONE);

  always_ff @(posedge PL_CLK_i or posedge PL_RESET_i) begin
    if (PL_RESET_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    CMD_READY_o    = 1'b0;
    WD_READY_o     = 1'b0;
    accept         = 1'b0;
    step           = 1'b0;
    ena_nxt        = 1'b0;
    wen_nxt        = 1'b0;
    ren_nxt        = 1'b0;
    addr_nxt       = PL_ADDR_o;
    data_nxt       = 18'd0;
    issue_nxt      = 1'b0;
    issue_last_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        // Ready is masked while reset is held so every output reads 0.
        CMD_READY_o = !PL_RESET_i;
        if (CMD_VALID_i && !PL_RESET_i) begin
          accept = 1'b1;
          if (cmd_illegal)              state_nxt = S_DONE;
          else if (CMD_OP_i == OP_WRITE) state_nxt = S_WRITE;
          else if (CMD_OP_i == OP_FILL)  state_nxt = S_FILL;
          else                           state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        WD_READY_o = 1'b1;
        // During a bubble the bus shows the pending address with no strobe.
        addr_nxt   = {ram_id, 2'b00, waddr};
        if (WD_VALID_i) begin
          step     = 1'b1;
          ena_nxt  = 1'b1;
          wen_nxt  = 1'b1;
          data_nxt = WD_DATA_i;
          if (remaining == 11'd1) state_nxt = S_DRAIN;
        end
      end
      S_FILL: begin
        step     = 1'b1;
        ena_nxt  = 1'b1;
        wen_nxt  = 1'b1;
        addr_nxt = {ram_id, 2'b00, waddr};
        data_nxt = fill_data;
        if (remaining == 11'd1) state_nxt = S_DRAIN;
      end
      S_READ: begin
        step           = 1'b1;
        ena_nxt        = 1'b1;
        ren_nxt        = 1'b1;
        addr_nxt       = {ram_id, 2'b00, waddr};
        issue_nxt      = 1'b1;
        issue_last_nxt = (remaining == 11'd1);
        if (remaining == 11'd1) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Reads keep REN up (same address) until the last word has had
        // READ_LAT cycles to come back; writes just let the final strobe
        // leave the bus so DONE trails it by one cycle.
        if (drain_cnt != '0) begin
          ena_nxt = 1'b1;
          ren_nxt = 1'b1;
        end
        if (!is_read || RD_LAST_o) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command context and burst counters.
  always_ff @(posedge PL_CLK_i or posedge PL_RESET_i) begin
    if (PL_RESET_i) begin
      ram_id    <= 20'd0;
      waddr     <= 10'd0;
      remaining <= 11'd0;
      fill_data <= 18'd0;
      is_read   <= 1'b0;
      drain_cnt <= '0;
      ERR_o     <= 1'b0;
    end else begin
      if (accept) begin
        ram_id    <= CMD_RAM_ID_i;
        waddr     <= CMD_ADDR_i;
        remaining <= CMD_LEN_i;
        fill_data <= CMD_FILL_i;
        is_read   <= (CMD_OP_i == OP_READ);
        drain_cnt <= (CMD_OP_i == OP_READ) ? DW'(READ_LAT) : '0;
        ERR_o     <= cmd_illegal;
      end else begin
        if (step) begin
          waddr     <= waddr + 10'd1;   // wraps modulo 1024
          remaining <= remaining - 11'd1;
        end
        if ((state == S_DRAIN) && (drain_cnt != '0))
          drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  // Registered bus outputs.
  always_ff @(posedge PL_CLK_i or posedge PL_RESET_i) begin
    if (PL_RESET_i) begin
      PL_ENA_o      <= 1'b0;
      PL_WEN_o      <= 1'b0;
      PL_REN_o      <= 1'b0;
      PL_ADDR_o     <= 32'd0;
      PL_DATA_o     <= 18'd0;
      rd_issue      <= 1'b0;
      rd_issue_last <= 1'b0;
    end else begin
      PL_ENA_o      <= ena_nxt;
      PL_WEN_o      <= wen_nxt;
      PL_REN_o      <= ren_nxt;
      PL_ADDR_o     <= addr_nxt;
      PL_DATA_o     <= data_nxt;
      rd_issue      <= issue_nxt;
      rd_issue_last <= issue_last_nxt;
    end
  end

  // Read capture: a word on the bus in cycle t is sampled from PL_RDATA_i at
  // the edge ending cycle t+READ_LAT.
  always_ff @(posedge PL_CLK_i or posedge PL_RESET_i) begin
    if (PL_RESET_i) begin
      vld_sr     <= '0;
      last_sr    <= '0;
      RD_VALID_o <= 1'b0;
      RD_LAST_o  <= 1'b0;
      RD_DATA_o  <= 18'd0;
    end else begin
      vld_sr[0]  <= rd_issue;
      last_sr[0] <= rd_issue_last;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      RD_VALID_o <= vld_sr[READ_LAT-1];
      RD_LAST_o  <= last_sr[READ_LAT-1];
      RD_DATA_o  <= vld_sr[READ_LAT-1] ? PL_RDATA_i : 18'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_preload_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_preload_master
// Purpose  : Directed self-checking bench for pl_preload_master with a single
//            tile model (id 0x00401, READ_LAT=1). Unwritten tile words read
//            back as addr^0x155; written words (incl. broadcast) are stored.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_preload_master;

  localparam logic [19:0] TILE_ID = 20'h00401;

  logic        clk, rst;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_OP;
  logic [19:0] CMD_RAM_ID;
  logic [9:0]  CMD_ADDR;
  logic [10:0] CMD_LEN;
  logic [17:0] CMD_FILL;
  logic        WD_VALID, WD_READY;
  logic [17:0] WD_DATA;
  logic        RD_VALID, RD_LAST, BUSY, DONE, ERR;
  logic [17:0] RD_DATA;
  logic        PL_ENA, PL_WEN, PL_REN;
  logic [31:0] PL_ADDR;
  logic [17:0] PL_DATA, PL_RDATA;

  int n_cmp = 0;
  int n_bad = 0;

  pl_preload_master #(.READ_LAT(1), .MAX_LEN(1024)) dut (
    .PL_CLK_i(clk), .PL_RESET_i(rst),
    .CMD_VALID_i(CMD_VALID), .CMD_READY_o(CMD_READY), .CMD_OP_i(CMD_OP),
    .CMD_RAM_ID_i(CMD_RAM_ID), .CMD_ADDR_i(CMD_ADDR), .CMD_LEN_i(CMD_LEN),
    .CMD_FILL_i(CMD_FILL),
    .WD_VALID_i(WD_VALID), .WD_READY_o(WD_READY), .WD_DATA_i(WD_DATA),
    .RD_VALID_o(RD_VALID), .RD_DATA_o(RD_DATA), .RD_LAST_o(RD_LAST),
    .BUSY_o(BUSY), .DONE_o(DONE), .ERR_o(ERR),
    .PL_ENA_o(PL_ENA), .PL_WEN_o(PL_WEN), .PL_REN_o(PL_REN),
    .PL_ADDR_o(PL_ADDR), .PL_DATA_o(PL_DATA), .PL_RDATA_i(PL_RDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile model, one cycle read latency, data only while REN is high.
  logic [17:0] mem     [1024];
  logic        wr_flag [1024];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) wr_flag[i] <= 1'b0;
      PL_RDATA <= '0;
    end else begin
      if (PL_ENA && PL_WEN && (PL_ADDR[31:12] == 20'd0 || PL_ADDR[31:12] == TILE_ID)) begin
        mem[PL_ADDR[9:0]]     <= PL_DATA;
        wr_flag[PL_ADDR[9:0]] <= 1'b1;
      end
      if (PL_ENA && PL_REN && PL_ADDR[31:12] == TILE_ID)
        PL_RDATA <= wr_flag[PL_ADDR[9:0]] ? mem[PL_ADDR[9:0]] : {8'h00, PL_ADDR[9:0] ^ 10'h155};
      else
        PL_RDATA <= '0;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input logic [1:0] op, input logic [19:0] id, input logic [9:0] a,
                          input logic [10:0] len, input logic [17:0] fill);
    logic got;
    got = 1'b0;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_RAM_ID = id; CMD_ADDR = a; CMD_LEN = len; CMD_FILL = fill;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk); got = CMD_READY;
      @(posedge clk); #1;
    end
    CMD_VALID = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL cmd_accept: ready=%0b expected 1", got); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({CMD_READY, WD_READY, RD_VALID, RD_DATA, RD_LAST, BUSY, DONE, ERR,
         PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA} !== 81'd0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero while in reset");
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({CMD_READY, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL reset_idle: ready,busy=%b expected 10", {CMD_READY, BUSY});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write(input int stall);
    int nw, bub, last_w, done_c, sent, stall_left;
    logic hs;
    logic [9:0] base;
    base = 10'h010;
    send_cmd(2'b00, TILE_ID, base, 11'd3, 18'd0);
    WD_VALID = 1'b1; WD_DATA = 18'd1;
    nw = 0; bub = 0; last_w = -1; done_c = -1; sent = 0; stall_left = stall;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (PL_ENA) begin
        n_cmp++;
        if ({PL_WEN, PL_REN, PL_ADDR, PL_DATA} !== {2'b10, TILE_ID, 2'b00, base + 10'(nw), 18'(nw + 1)}) begin
          n_bad++;
          $display("FAIL write_beat%0d: wen=%b addr=%h data=%h expected addr=%h data=%h", nw,
                   PL_WEN, PL_ADDR, PL_DATA, {TILE_ID, 2'b00, base + 10'(nw)}, 18'(nw + 1));
        end
        nw++; last_w = c;
      end else if (nw > 0 && nw < 3) begin
        bub++;
        n_cmp++;
        if ({PL_WEN, PL_ADDR, PL_DATA} !== {1'b0, TILE_ID, 2'b00, base + 10'(nw), 18'd0}) begin
          n_bad++;
          $display("FAIL write_bubble: wen=%b addr=%h data=%h expected addr=%h", PL_WEN, PL_ADDR,
                   PL_DATA, {TILE_ID, 2'b00, base + 10'(nw)});
        end
      end
      if (DONE) done_c = c;
      hs = WD_VALID && WD_READY;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        WD_DATA = 18'(sent + 1);
        if (sent == 3 || (sent == 1 && stall_left > 0)) WD_VALID = 1'b0;
      end else if (!WD_VALID && sent < 3 && stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) WD_VALID = 1'b1;
      end
    end
    WD_VALID = 1'b0;
    n_cmp++;
    if (nw != 3) begin n_bad++; $display("FAIL write_count: got %0d expected 3", nw); end
    n_cmp++;
    if (bub != stall) begin n_bad++; $display("FAIL write_bubbles: got %0d expected %0d", bub, stall); end
    n_cmp++;
    if (done_c != last_w + 1) begin
      n_bad++; $display("FAIL write_done: done cycle %0d expected %0d", done_c, last_w + 1);
    end
  endtask

  task automatic test_read(input logic [9:0] a, input int len, input logic fill_mode);
    int nr, nv, first_r, last_r, first_v, last_v, done_c;
    logic [9:0]  ea;
    logic [17:0] ed;
    send_cmd(2'b01, TILE_ID, a, 11'(len), 18'd0);
    nr = 0; nv = 0; first_r = -1; last_r = -1; first_v = -1; last_v = -1; done_c = -1;
    for (int c = 0; c < len + 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (PL_REN) begin
        ea = (nr < len) ? a + 10'(nr) : a + 10'(len - 1);
        n_cmp++;
        if ({PL_ENA, PL_WEN, PL_ADDR} !== {2'b10, TILE_ID, 2'b00, ea}) begin
          n_bad++;
          $display("FAIL read_issue%0d: ena=%b wen=%b addr=%h expected addr=%h", nr, PL_ENA, PL_WEN,
                   PL_ADDR, {TILE_ID, 2'b00, ea});
        end
        if (first_r < 0) first_r = c;
        last_r = c; nr++;
      end
      if (RD_VALID) begin
        ea = a + 10'(nv);
        ed = fill_mode ? 18'h3FFFF : {8'h00, ea ^ 10'h155};
        n_cmp++;
        if ({RD_DATA, RD_LAST} !== {ed, 1'(nv == len - 1)}) begin
          n_bad++;
          $display("FAIL read_data%0d: data=%h last=%b expected data=%h last=%b", nv, RD_DATA,
                   RD_LAST, ed, 1'(nv == len - 1));
        end
        if (first_v < 0) first_v = c;
        last_v = c; nv++;
      end
      if (DONE) done_c = c;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nr != len + 1 || last_r - first_r != len) begin
      n_bad++; $display("FAIL read_ren_window: cycles=%0d span=%0d expected %0d", nr, last_r - first_r + 1, len + 1);
    end
    n_cmp++;
    if (nv != len || last_v - first_v != len - 1) begin
      n_bad++; $display("FAIL read_valid_count: got %0d span %0d expected %0d", nv, last_v - first_v + 1, len);
    end
    n_cmp++;
    if (done_c != last_v + 1) begin
      n_bad++; $display("FAIL read_done: done cycle %0d expected %0d", done_c, last_v + 1);
    end
  endtask

  task automatic test_fill();
    int nw, bad, first_w, last_w, done_c;
    send_cmd(2'b10, 20'd0, 10'd0, 11'd1024, 18'h3FFFF);
    nw = 0; bad = 0; first_w = -1; last_w = -1; done_c = -1;
    for (int c = 0; c < 1100 && done_c < 0; c++) begin
      @(negedge clk);
      if (PL_ENA) begin
        if ({PL_WEN, PL_REN, PL_ADDR, PL_DATA} !== {2'b10, 20'd0, 2'b00, 10'(nw), 18'h3FFFF}) bad++;
        if (first_w < 0) first_w = c;
        last_w = c; nw++;
      end
      if (DONE) done_c = c;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nw != 1024 || last_w - first_w != 1023) begin
      n_bad++; $display("FAIL fill_count: got %0d span %0d expected 1024", nw, last_w - first_w + 1);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL fill_beats: %0d bad beats expected 0", bad); end
    n_cmp++;
    if (done_c != last_w + 1) begin
      n_bad++; $display("FAIL fill_done: done cycle %0d expected %0d", done_c, last_w + 1);
    end
    test_read(10'h3FE, 4, 1'b1);
  endtask

  task automatic test_illegal();
    logic ena_seen;
    int   dones, done_c;
    logic hs;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: send_cmd(2'b11, TILE_ID, 10'd0, 11'd4, 18'd0);
        1: send_cmd(2'b00, TILE_ID, 10'd0, 11'd0, 18'd0);
        2: send_cmd(2'b00, TILE_ID, 10'd0, 11'd1025, 18'd0);
        default: send_cmd(2'b01, 20'd0, 10'd0, 11'd4, 18'd0);
      endcase
      ena_seen = 1'b0; dones = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (PL_ENA) ena_seen = 1'b1;
        if (DONE) dones++;
        @(posedge clk); #1;
      end
      n_cmp++;
      if ({ena_seen, 2'(dones), ERR} !== 4'b0011) begin
        n_bad++; $display("FAIL illegal%0d: ena=%b dones=%0d err=%b expected 0/1/1", k, ena_seen, dones, ERR);
      end
    end
    send_cmd(2'b00, TILE_ID, 10'h020, 11'd1, 18'd0);
    WD_VALID = 1'b1; WD_DATA = 18'h00ABC;
    @(negedge clk);
    n_cmp++;
    if (ERR !== 1'b0) begin n_bad++; $display("FAIL err_clear: err=%b expected 0", ERR); end
    done_c = -1;
    for (int c = 0; c < 10 && done_c < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (DONE) done_c = c;
      hs = WD_VALID && WD_READY;
      @(posedge clk); #1;
      if (hs) WD_VALID = 1'b0;
    end
    WD_VALID = 1'b0;
    n_cmp++;
    if (done_c < 0) begin n_bad++; $display("FAIL legal_done: done=0 expected 1"); end
  endtask

  task automatic test_reset_midread();
    logic stray;
    send_cmd(2'b01, TILE_ID, 10'd0, 11'd8, 18'd0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (PL_REN !== 1'b1) begin n_bad++; $display("FAIL midread_active: ren=%b expected 1", PL_REN); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({CMD_READY, WD_READY, RD_VALID, RD_DATA, RD_LAST, BUSY, DONE, ERR,
         PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA} !== 81'd0) begin
      n_bad++; $display("FAIL midread_reset: ena=%b ren=%b addr=%h busy=%b rdv=%b expected all 0",
                        PL_ENA, PL_REN, PL_ADDR, BUSY, RD_VALID);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({CMD_READY, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL midread_idle: ready,busy=%b expected 10", {CMD_READY, BUSY});
    end
    stray = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (RD_VALID || PL_ENA) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin n_bad++; $display("FAIL midread_stray: activity=%b expected 0", stray); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_RAM_ID = '0; CMD_ADDR = '0; CMD_LEN = '0; CMD_FILL = '0;
    WD_VALID = 1'b0; WD_DATA = '0;
    #2;
    test_reset();
    test_write(0);
    test_write(2);
    test_read(10'h3FE, 4, 1'b0);
    test_fill();
    test_illegal();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
